// File: rtl/async_fifo_wctrl.sv
// async_fifo_wctrl: write-side controller of the async FIFO (wclk domain).
// Drives the RAM write port and keeps the binary and Gray write pointers.
// Synchronizes the read Gray pointer and derives full, almost-full, level and
// a sticky overflow flag.
module async_fifo_wctrl #(
  parameter int unsigned AWIDTH       = 9,
  parameter int unsigned AFULL_THRESH = 2**AWIDTH - 4
) (
  input  logic              wclk,
  input  logic              arst_n,
  input  logic              winc,
  input  logic              wclr_ovf,
  input  logic [AWIDTH:0]   rptr_gray,
  output logic              wen,
  output logic [AWIDTH-1:0] waddr,
  output logic [AWIDTH:0]   wptr_gray,
  output logic              wfull,
  output logic              walmost_full,
  output logic [AWIDTH:0]   wlevel,
  output logic              wovf
);

  localparam logic [AWIDTH:0] LP_AFULL = (AWIDTH+1)'(AFULL_THRESH);

  logic [AWIDTH:0] r_wbin;
  logic [AWIDTH:0] r_wgray;
  logic [AWIDTH:0] r_rq1;
  logic [AWIDTH:0] r_rq2;
  logic            r_wfull;
  logic            r_walmost_full;
  logic [AWIDTH:0] r_wlevel;
  logic            r_wovf;

  logic            w_wen;
  logic [AWIDTH:0] w_wbin_next;
  logic [AWIDTH:0] w_wgray_next;
  logic [AWIDTH:0] w_rbin_sync;
  logic [AWIDTH:0] w_full_cmp;
  logic [AWIDTH:0] w_level_next;

  // Accept logic; gated by arst_n so the RAM is never written while in reset.
  always_comb begin
    w_wen        = winc & ~r_wfull & arst_n;
    w_wbin_next  = r_wbin + {{AWIDTH{1'b0}}, w_wen};
    w_wgray_next = (w_wbin_next >> 1) ^ w_wbin_next;
    w_full_cmp   = {~r_rq2[AWIDTH:AWIDTH-1], r_rq2[AWIDTH-2:0]};
  end

  // Gray-to-binary of the synchronized read pointer: bit i is the XOR of all
  // Gray bits at or above i.
  always_comb begin
    w_rbin_sync = '0;
    for (int unsigned i = 0; i <= AWIDTH; i++) begin
      w_rbin_sync[i] = ^(r_rq2 >> i);
    end
    w_level_next = w_wbin_next - w_rbin_sync;
  end

  // Two-flop synchronizer for the read-domain Gray pointer.
  always_ff @(posedge wclk or negedge arst_n) begin
    if (!arst_n) begin
      r_rq1 <= '0;
      r_rq2 <= '0;
    end else begin
      r_rq1 <= rptr_gray;
      r_rq2 <= r_rq1;
    end
  end

  // Write pointers and registered status flags.
  always_ff @(posedge wclk or negedge arst_n) begin
    if (!arst_n) begin
      r_wbin         <= '0;
      r_wgray        <= '0;
      r_wfull        <= 1'b0;
      r_walmost_full <= 1'b0;
      r_wlevel       <= '0;
    end else begin
      r_wbin         <= w_wbin_next;
      r_wgray        <= w_wgray_next;
      r_wfull        <= (w_wgray_next == w_full_cmp);
      r_walmost_full <= (w_level_next >= LP_AFULL);
      r_wlevel       <= w_level_next;
    end
  end

  // Sticky overflow: a rejected write sets it, and set beats a same-cycle clear.
  always_ff @(posedge wclk or negedge arst_n) begin
    if (!arst_n) begin
      r_wovf <= 1'b0;
    end else if (winc & r_wfull) begin
      r_wovf <= 1'b1;
    end else if (wclr_ovf) begin
      r_wovf <= 1'b0;
    end
  end

  assign wen          = w_wen;
  assign waddr        = r_wbin[AWIDTH-1:0];
  assign wptr_gray    = r_wgray;
  assign wfull        = r_wfull;
  assign walmost_full = r_walmost_full;
  assign wlevel       = r_wlevel;
  assign wovf         = r_wovf;

endmodule

// File: tb/tb_async_fifo_wctrl.sv
// tb_async_fifo_wctrl: directed and randomized bench for async_fifo_wctrl
// (AWIDTH=4, AFULL_THRESH=12) against an occupancy-count reference model.
module tb_async_fifo_wctrl;

  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int THR   = 12;

  logic          wclk = 1'b0;
  logic          arst_n = 1'b0;
  logic          winc = 1'b0;
  logic          wclr_ovf = 1'b0;
  logic [AW:0]   rptr_gray = '0;
  logic          wen;
  logic [AW-1:0] waddr;
  logic [AW:0]   wptr_gray;
  logic          wfull;
  logic          walmost_full;
  logic [AW:0]   wlevel;
  logic          wovf;

  async_fifo_wctrl #(.AWIDTH(AW), .AFULL_THRESH(THR)) dut (
    .wclk(wclk), .arst_n(arst_n), .winc(winc), .wclr_ovf(wclr_ovf),
    .rptr_gray(rptr_gray), .wen(wen), .waddr(waddr), .wptr_gray(wptr_gray),
    .wfull(wfull), .walmost_full(walmost_full), .wlevel(wlevel), .wovf(wovf)
  );

  always #5 wclk = ~wclk;

  int checks = 0;
  int errors = 0;

  // Reference model: total words written and read (unbounded counts), with the
  // read count seen through a two-stage delay.
  int m_wr, m_rd, m_rq1, m_rq2, m_level;
  bit m_full, m_afull, m_ovf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW:0] to_gray(input int n);
    logic [AW:0] b;
    b = n[AW:0];
    return b ^ (b >> 1);
  endfunction

  task automatic set_rd(input int n);
    m_rd = n;
    rptr_gray = to_gray(n);
  endtask

  task automatic model_reset();
    m_wr = 0; m_rd = 0; m_rq1 = 0; m_rq2 = 0; m_level = 0;
    m_full = 0; m_afull = 0; m_ovf = 0;
  endtask

  task automatic check_regs();
    chk("waddr_r", waddr, m_wr % DEPTH);
    chk("wptr_gray", wptr_gray, to_gray(m_wr));
    chk("wfull", wfull, m_full);
    chk("walmost_full", walmost_full, m_afull);
    chk("wlevel", wlevel, m_level);
    chk("wovf", wovf, m_ovf);
  endtask

  task automatic check_all_zero();
    chk("rst_wen", wen, 0);
    chk("rst_waddr", waddr, 0);
    chk("rst_wptr_gray", wptr_gray, 0);
    chk("rst_wfull", wfull, 0);
    chk("rst_walmost_full", walmost_full, 0);
    chk("rst_wlevel", wlevel, 0);
    chk("rst_wovf", wovf, 0);
  endtask

  // One wclk cycle with the current inputs; checks combinational outputs
  // before the edge and registered outputs after it.
  task automatic cycle();
    bit exp_wen;
    #1;
    exp_wen = winc && !m_full;
    chk("wen", wen, exp_wen);
    if (exp_wen) chk("waddr", waddr, m_wr % DEPTH);
    @(posedge wclk);
    if (winc && m_full) m_ovf = 1;
    else if (wclr_ovf) m_ovf = 0;
    if (exp_wen) m_wr++;
    m_level = m_wr - m_rq2;
    m_rq2 = m_rq1;
    m_rq1 = m_rd;
    m_full  = (m_level == DEPTH);
    m_afull = (m_level >= THR);
    #1;
    check_regs();
  endtask

  task automatic do_reset();
    @(posedge wclk);
    #3;
    arst_n = 1'b0;
    #1;
    check_all_zero();
    winc = 1'b0;
    wclr_ovf = 1'b0;
    model_reset();
    set_rd(0);
    @(negedge wclk);
    arst_n = 1'b1;
  endtask

  initial begin
    logic [AW:0] prev_g;
    int hist[$];
    bit saw_wrap;

    // Reset held with an active request and a non-zero read pointer.
    model_reset();
    arst_n = 1'b0;
    winc = 1'b1;
    rptr_gray = 5'b10110;
    #12;
    check_all_zero();
    @(posedge wclk);
    #1;
    check_all_zero();
    @(negedge wclk);
    winc = 1'b0;
    set_rd(0);
    arst_n = 1'b1;

    // Fill: 17 back-to-back requests with the reader idle.
    winc = 1'b1;
    for (int n = 1; n <= 17; n++) begin
      if (n == 1) begin
        #1;
        chk("first_waddr", waddr, 0);
      end
      cycle();
      if (n <= 16) begin
        chk("fill_afull", walmost_full, (n >= THR) ? 1 : 0);
        chk("fill_full", wfull, (n >= DEPTH) ? 1 : 0);
        chk("fill_level", wlevel, n);
      end
      if (n == 16) chk("full_gray", wptr_gray, 5'b11000);
      if (n == 17) chk("ovf_set", wovf, 1);
    end

    // Overflow clear: set wins over clear, then clear alone.
    wclr_ovf = 1'b1;
    cycle();
    chk("ovf_set_wins", wovf, 1);
    winc = 1'b0;
    cycle();
    chk("ovf_cleared", wovf, 0);
    wclr_ovf = 1'b0;

    // Drain response: one word read, seen three edges later.
    set_rd(1);
    cycle();
    chk("drain_e1_full", wfull, 1);
    cycle();
    chk("drain_e2_full", wfull, 1);
    cycle();
    chk("drain_e3_full", wfull, 0);
    chk("drain_e3_level", wlevel, 15);
    winc = 1'b1;
    #1;
    chk("drain_wen", wen, 1);
    chk("drain_waddr", waddr, 0);
    cycle();
    winc = 1'b0;

    // Mid-stream reset after 7 accepts.
    do_reset();
    winc = 1'b1;
    for (int n = 0; n < 7; n++) cycle();
    chk("pre_rst_waddr", waddr, 7);
    do_reset();
    winc = 1'b1;
    #1;
    chk("post_rst_waddr", waddr, 0);
    cycle();

    // Wrap: 40 writes, reader follows the write count three cycles behind.
    prev_g = wptr_gray;
    saw_wrap = 0;
    for (int n = 0; n < 40; n++) begin
      hist.push_back(m_wr);
      if (hist.size() > 3) set_rd(hist.pop_front());
      cycle();
      chk("wrap_full", wfull, 0);
      chk("gray_step", $countones(wptr_gray ^ prev_g), 1);
      if (m_wr % 32 == 0) begin
        chk("wrap_zero", wptr_gray, 0);
        saw_wrap = 1;
      end
      prev_g = wptr_gray;
    end
    chk("saw_wrap", saw_wrap, 1);
    winc = 1'b0;

    // Randomized traffic: slow reader first (reaches full), then fast reader.
    for (int n = 0; n < 400; n++) begin
      winc = ($urandom_range(0, 99) < 70);
      wclr_ovf = ($urandom_range(0, 99) < 10);
      if (m_rd < m_wr && $urandom_range(0, 99) < ((n < 200) ? 20 : 60))
        set_rd(m_rd + 1);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
